// File: rtl/ram_master.sv
// ram_master: turns valid/ready read/write commands into the ram select-strobe protocol.
// Each beat runs SETUP -> STROBE -> HOLD; reads may burst with wrapping addresses.
module ram_master #(
  parameter int word_size   = 20,
  parameter int word_amount = 30,
  localparam int AW = $clog2(word_amount) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [AW-1:0]      cmd_addr,
  input  logic [7:0]         cmd_len,
  input  logic [word_size:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [word_size:0] rsp_data,
  output logic               done,
  output logic               err,
  output logic               busy,
  output logic [AW-1:0]      mem_address,
  output logic               mem_select,
  output logic               mem_operation,
  output logic [word_size:0] mem_wdata,
  input  logic [word_size:0] mem_rdata
);

  localparam logic [AW-1:0] MAX_ADDR = AW'(word_amount);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t               r_state;
  logic [7:0]           r_beats;
  logic [AW-1:0]        r_mem_address;
  logic                 r_mem_select;
  logic                 r_mem_operation;
  logic [word_size:0]   r_mem_wdata;
  logic                 r_rsp_valid;
  logic [word_size:0]   r_rsp_data;
  logic                 r_done;
  logic                 r_err;
  logic                 r_busy;

  logic                 w_addr_bad;
  logic                 w_more_beats;
  logic [AW-1:0]        w_next_addr;

  assign w_addr_bad   = (cmd_addr > MAX_ADDR);
  assign w_more_beats = !r_mem_operation && (r_beats != 8'd0);
  assign w_next_addr  = (r_mem_address == MAX_ADDR) ? '0 : r_mem_address + AW'(1);

  // Ready is forced low while reset is held so the client only sees it after release.
  assign cmd_ready     = !rst && (r_state == S_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign done          = r_done;
  assign err           = r_err;
  assign busy          = r_busy;
  assign mem_address   = r_mem_address;
  assign mem_select    = r_mem_select;
  assign mem_operation = r_mem_operation;
  assign mem_wdata     = r_mem_wdata;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking updates would leak new values within the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_beats         <= '0;
      r_mem_address   <= '0;
      r_mem_select    <= 1'b0;
      r_mem_operation <= 1'b0;
      r_mem_wdata     <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= '0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_addr_bad) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_state         <= S_SETUP;
              r_busy          <= 1'b1;
              r_mem_address   <= cmd_addr;
              r_mem_operation <= cmd_op;
              r_mem_wdata     <= cmd_wdata;
              r_beats         <= cmd_op ? 8'd0 : cmd_len;
            end
          end
        end
        S_SETUP: begin
          r_state      <= S_STROBE;
          r_mem_select <= 1'b1;
        end
        S_STROBE: begin
          r_state      <= S_HOLD;
          r_mem_select <= 1'b0;
        end
        S_HOLD: begin
          if (!r_mem_operation) begin
            r_rsp_data  <= mem_rdata;
            r_rsp_valid <= 1'b1;
          end
          if (w_more_beats) begin
            r_state       <= S_SETUP;
            r_beats       <= r_beats - 8'd1;
            r_mem_address <= w_next_addr;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: behavioural ram device, array memory model, directed cases
// from the plan plus randomized commands with cycle-accurate response expectations.
module tb_ram_master;

  localparam int WS = 20;
  localparam int WA = 30;
  localparam int AW = $clog2(WA) + 1;
  localparam int DW = WS + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          done;
  logic          err;
  logic          busy;
  logic [AW-1:0] mem_address;
  logic          mem_select;
  logic          mem_operation;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int sel_pulses = 0;

  int            exp_mem [0:WA];
  logic [DW-1:0] ram     [0:WA];

  ram_master #(.word_size(WS), .word_amount(WA)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err), .busy(busy),
    .mem_address(mem_address), .mem_select(mem_select), .mem_operation(mem_operation),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // The ram acts only on the rising edge of select.
  always @(posedge mem_select) begin
    if (mem_operation) ram[mem_address] <= mem_wdata;
    else               mem_rdata <= ram[mem_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Address/operation/data must be identical one cycle before and after each strobe.
  logic          p1_sel = 1'b0, p2_sel = 1'b0;
  logic [AW-1:0] p1_addr, p2_addr;
  logic          p1_op, p2_op;
  logic [DW-1:0] p1_wd, p2_wd;
  always @(negedge clk) begin
    if (!rst && p1_sel) begin
      check("hold_sel_low", {31'd0, mem_select}, 0);
      check("setup_sel_low", {31'd0, p2_sel}, 0);
      check("setup_addr", {26'd0, p2_addr}, {26'd0, p1_addr});
      check("hold_addr", {26'd0, mem_address}, {26'd0, p1_addr});
      check("setup_op", {31'd0, p2_op}, {31'd0, p1_op});
      check("hold_op", {31'd0, mem_operation}, {31'd0, p1_op});
      check("setup_wdata", {11'd0, p2_wd}, {11'd0, p1_wd});
      check("hold_wdata", {11'd0, mem_wdata}, {11'd0, p1_wd});
    end
    if (mem_select && !p1_sel) sel_pulses++;
    p2_sel = p1_sel;  p2_addr = p1_addr;  p2_op = p1_op;  p2_wd = p1_wd;
    p1_sel = mem_select; p1_addr = mem_address; p1_op = mem_operation; p1_wd = mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command in cycle 0 and follow it to done; expectations come from
  // the beat count (3N+1 rule), the wrapped address sequence and exp_mem.
  task automatic run_cmd(input logic op, input int addr, input int len, input logic [DW-1:0] wd);
    int  n_beats, exp_done, cyc, rsp_idx, beat, a, sel_start;
    bit  oor, got_done;
    oor      = (addr > WA);
    n_beats  = op ? 1 : len + 1;
    exp_done = oor ? 1 : 3 * n_beats + 1;
    check("ready_at_issue", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = AW'(addr); cmd_len = 8'(len); cmd_wdata = wd;
    sel_start = sel_pulses;
    step();
    cmd_valid = 1'b0;
    cmd_wdata = DW'($urandom);
    cmd_addr  = AW'($urandom);
    cyc = 1; rsp_idx = 0; a = addr; got_done = 0;
    while (!got_done && cyc <= exp_done + 4) begin
      if (!oor && cyc < exp_done) begin
        check("ready_low_busy", {31'd0, cmd_ready}, 0);
        check("busy_high", {31'd0, busy}, 1);
      end
      if (mem_select) begin
        beat = (cyc - 2) / 3;
        check("sel_phase", (cyc - 2) % 3, 0);
        check("sel_addr", {26'd0, mem_address}, (addr + beat) % (WA + 1));
        check("sel_op", {31'd0, mem_operation}, {31'd0, op});
        if (op) check("sel_wdata", {11'd0, mem_wdata}, {11'd0, wd});
      end
      if (rsp_valid) begin
        check("rsp_cycle", cyc, 3 * (rsp_idx + 1) + 1);
        check("rsp_data", {11'd0, rsp_data}, exp_mem[a]);
        a = (a == WA) ? 0 : a + 1;
        rsp_idx++;
      end
      if (done) begin
        got_done = 1;
        check("done_cycle", cyc, exp_done);
        check("err_flag", {31'd0, err}, {31'd0, oor});
        check("ready_at_done", {31'd0, cmd_ready}, 1);
      end
      step();
      cyc++;
    end
    check("done_seen", {31'd0, got_done}, 1);
    check("rsp_count", rsp_idx, (oor || op) ? 0 : n_beats);
    check("sel_pulses", sel_pulses - sel_start, oor ? 0 : n_beats);
    if (op && !oor) exp_mem[addr] = int'(wd);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] b2b_data [3];
    int            idx;
    bit            accepted;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;
    repeat (2) step();
    check("rst_select", {31'd0, mem_select}, 0);
    check("rst_address", {26'd0, mem_address}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_rsp_data", {11'd0, rsp_data}, 0);
    rst = 1'b0;
    step();
    check("ready_after_rst", {31'd0, cmd_ready}, 1);

    // Fill every word so any later read has a known expectation.
    for (int i = 0; i <= WA; i++) run_cmd(1'b1, i, 0, DW'($urandom));

    // Write then read.
    run_cmd(1'b1, 5, 0, DW'(32'h12345));
    run_cmd(1'b0, 5, 0, '0);

    // Burst wrap across the top address.
    run_cmd(1'b1, 29, 0, DW'(32'hA));
    run_cmd(1'b1, 30, 0, DW'(32'hB));
    run_cmd(1'b1, 0,  0, DW'(32'hC));
    run_cmd(1'b0, 29, 2, '0);

    // Out-of-range address.
    run_cmd(1'b0, 31, 0, '0);
    check("oor_ready_after", {31'd0, cmd_ready}, 1);

    // Back-to-back writes with cmd_valid held high.
    for (int i = 0; i < 3; i++) b2b_data[i] = DW'($urandom);
    idx = 0;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = AW'(10); cmd_wdata = b2b_data[0];
    for (int c = 0; c < 12; c++) begin
      check("b2b_ready", {31'd0, cmd_ready}, {31'd0, (c % 4) == 0});
      check("b2b_done", {31'd0, done}, {31'd0, (c % 4) == 0 && c > 0});
      accepted = cmd_valid && cmd_ready;
      step();
      if (accepted) begin
        exp_mem[10 + idx] = int'(b2b_data[idx]);
        idx++;
        if (idx < 3) begin
          cmd_addr  = AW'(10 + idx);
          cmd_wdata = b2b_data[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    check("b2b_done_last", {31'd0, done}, 1);
    check("b2b_accepts", idx, 3);
    step();
    run_cmd(1'b0, 10, 2, '0);

    // Reset during the strobe of beat 2 of a 4-beat read.
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = AW'(3); cmd_len = 8'd3;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    check("pre_rst_strobe", {31'd0, mem_select}, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_select", {31'd0, mem_select}, 0);
    check("mid_rst_address", {26'd0, mem_address}, 0);
    check("mid_rst_op", {31'd0, mem_operation}, 0);
    check("mid_rst_wdata", {11'd0, mem_wdata}, 0);
    check("mid_rst_rsp", {31'd0, rsp_valid}, 0);
    check("mid_rst_rsp_data", {11'd0, rsp_data}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done_err", {30'd0, done, err}, 0);
    step();
    check("rst_no_done", {31'd0, done}, 0);
    rst = 1'b0;
    step();
    check("rst_release_ready", {31'd0, cmd_ready}, 1);
    check("rst_release_done", {31'd0, done}, 0);
    run_cmd(1'b0, 3, 3, '0);

    // Randomized mix including out-of-range addresses and long bursts.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) step();
      run_cmd(1'($urandom_range(0, 1)), $urandom_range(0, WA + 3), $urandom_range(0, 5),
              DW'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
